// File: rtl/afpm_operand_tx.sv
// Host-side byte-serial transmitter for the log-FP multiplier operand lanes.
// Takes one {A,B} pair at a time and sends it low byte first on two 8-bit lanes, followed by an idle gap.
//
// state | meaning
// IDLE  | lanes quiet, waiting for a pending pair
// SEND  | one byte of A and one byte of B on the lanes each cycle
// GAP   | lanes quiet for GAP_CYCLES so the multiplier can finish
module afpm_operand_tx #(
  parameter int NBYTES     = 2,
  parameter int GAP_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            a_byte,
  output logic [7:0]            b_byte,
  output logic                  byte_valid,
  output logic                  frame_first,
  output logic                  frame_last,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NBYTES - 1);
  localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t         state, state_d;
  logic           pend_full;
  logic [W-1:0]   pend_a, pend_b;
  logic [W-1:0]   sh_a, sh_b;
  logic [CW-1:0]  cnt;
  logic [GW-1:0]  gcnt;
  logic           load, accept, last_byte, last_gap;

  assign in_ready  = !pend_full;
  assign accept    = in_valid && !pend_full;
  assign last_byte = (cnt == C_LAST);
  assign last_gap  = (gcnt == G_LAST);

  always_comb begin
    state_d = state;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (pend_full) begin
          state_d = SEND;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (last_byte) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
          end else if (pend_full) begin
            state_d = SEND;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (last_gap) begin
          if (pend_full) begin
            state_d = SEND;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Accept and load are mutually exclusive: accept needs pend_full low, load needs it high.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= 1'b0;
      pend_a    <= '0;
      pend_b    <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      cnt       <= '0;
      gcnt      <= '0;
    end else begin
      if (accept) begin
        pend_a    <= in_a;
        pend_b    <= in_b;
        pend_full <= 1'b1;
      end else if (load) begin
        pend_full <= 1'b0;
      end

      if (load) begin
        sh_a <= pend_a;
        sh_b <= pend_b;
        cnt  <= '0;
      end else if (state == SEND) begin
        sh_a <= sh_a >> 8;
        sh_b <= sh_b >> 8;
        cnt  <= last_byte ? '0 : cnt + CW'(1);
      end

      if (state == GAP) gcnt <= last_gap ? '0 : gcnt + GW'(1);
      else              gcnt <= '0;
    end
  end

  assign byte_valid  = (state == SEND);
  assign a_byte      = byte_valid ? sh_a[7:0] : 8'h00;
  assign b_byte      = byte_valid ? sh_b[7:0] : 8'h00;
  assign frame_first = byte_valid && (cnt == '0);
  assign frame_last  = byte_valid && last_byte;
  assign busy        = (state != IDLE) || pend_full;

endmodule

// File: tb/tb_afpm_operand_tx.sv
// Bench for afpm_operand_tx: two instances (gap 3 and gap 0) checked cycle by cycle
// against a frame-timing reference model and a per-byte expectation queue.
module tb_afpm_operand_tx;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] ia [2];
  logic [15:0] ib [2];
  logic        iv [2];
  logic        rdy[2], bv[2], ff[2], fl[2], bz[2];
  logic [7:0]  ab [2], bb[2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       f;
    logic       l;
    int         c;
  } exp_t;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t act=%0h exp=%0h", name, inst, $time, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int GAP = (gi == 0) ? 3 : 0;

    exp_t q[$];
    int ecnt      = 0;
    int pend_lo   = 0;
    int pend_hi   = -1;
    int next_free = 0;
    int busy_from = 0;

    afpm_operand_tx #(.NBYTES(NB), .GAP_CYCLES(GAP)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_a        (ia[gi]),
      .in_b        (ib[gi]),
      .in_valid    (iv[gi]),
      .in_ready    (rdy[gi]),
      .a_byte      (ab[gi]),
      .b_byte      (bb[gi]),
      .byte_valid  (bv[gi]),
      .frame_first (ff[gi]),
      .frame_last  (fl[gi]),
      .busy        (bz[gi])
    );

    // Frame-level model: a frame accepted at edge e starts at the later of e+1 and the
    // end of the previous frame's bytes plus gap; the buffer is occupied until it starts.
    always @(posedge clk) begin : model
      int e, s;
      exp_t x;
      ecnt++;
      e = ecnt;
      if (rst) begin
        q.delete();
        pend_lo   = 0;
        pend_hi   = -1;
        next_free = 0;
        busy_from = 0;
      end else if (iv[gi] && !((e - 1) >= pend_lo && (e - 1) <= pend_hi)) begin
        s = (e + 1 > next_free) ? e + 1 : next_free;
        if (e >= next_free) busy_from = e;
        pend_lo   = e;
        pend_hi   = s - 1;
        next_free = s + NB + GAP;
        for (int k = 0; k < NB; k++) begin
          x.a = 8'(ia[gi] >> (8 * k));
          x.b = 8'(ib[gi] >> (8 * k));
          x.f = (k == 0);
          x.l = (k == NB - 1);
          x.c = s + k;
          q.push_back(x);
        end
      end
    end

    always @(negedge clk) begin : mon
      int c;
      logic xr, xb, xv;
      exp_t x;
      c = ecnt;
      while (q.size() > 0 && q[0].c < c) begin
        x = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_byte inst%0d t=%0t act=none exp=%02h/%02h", gi, $time, x.a, x.b);
      end
      xr = !(c >= pend_lo && c <= pend_hi);
      xb = (c >= busy_from && c < next_free) || !xr;
      xv = (q.size() > 0) && (q[0].c == c);
      chk("in_ready",   gi, 32'(rdy[gi]), 32'(xr));
      chk("busy",       gi, 32'(bz[gi]),  32'(xb));
      chk("byte_valid", gi, 32'(bv[gi]),  32'(xv));
      if (xv) begin
        x = q.pop_front();
        chk("a_byte",      gi, 32'(ab[gi]), 32'(x.a));
        chk("b_byte",      gi, 32'(bb[gi]), 32'(x.b));
        chk("frame_first", gi, 32'(ff[gi]), 32'(x.f));
        chk("frame_last",  gi, 32'(fl[gi]), 32'(x.l));
      end else begin
        chk("a_idle",     gi, 32'(ab[gi]), 32'h0);
        chk("b_idle",     gi, 32'(bb[gi]), 32'h0);
        chk("first_idle", gi, 32'(ff[gi]), 32'h0);
        chk("last_idle",  gi, 32'(fl[gi]), 32'h0);
      end
    end
  end

  task automatic send(input int i, input logic [15:0] a, input logic [15:0] b);
    logic r;
    int n;
    n = 0;
    ia[i] = a;
    ib[i] = b;
    iv[i] = 1'b1;
    do begin
      r = rdy[i];
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    checks++;
    if (!r) begin
      errors++;
      $display("FAIL accept_timeout inst%0d t=%0t act=no_transfer exp=transfer", i, $time);
    end
  endtask

  task automatic idle(input int i, input int n);
    iv[i] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      ia[i] = '0;
      ib[i] = '0;
      iv[i] = 1'b0;
    end
    // Reset with a valid pair present: nothing may be captured.
    iv[0] = 1'b1;
    ia[0] = 16'hFFFF;
    ib[0] = 16'hFFFF;
    rst   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    iv[0] = 1'b0;
    rst   = 1'b0;
    idle(0, 2);

    send(0, 16'h3E00, 16'h4200);
    idle(0, 8);

    send(0, 16'h0101, 16'h0101);
    send(0, 16'h3E00, 16'h4200);
    send(0, 16'h1234, 16'hABCD);
    idle(0, 12);

    // Third pair is stalled while the second sits in the pending buffer.
    send(0, 16'h1111, 16'h2222);
    send(0, 16'h3333, 16'h4444);
    send(0, 16'h5555, 16'h6666);
    idle(0, 15);

    // Reset during byte 0 with another pair offered.
    send(0, 16'h3E00, 16'h4200);
    ia[0] = 16'hBEEF;
    ib[0] = 16'hCAFE;
    iv[0] = 1'b1;
    n = 0;
    while (!ff[0] && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst   = 1'b1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(0, 8);

    repeat (25) begin
      send(0, 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 2) == 0) idle(0, $urandom_range(1, 8));
    end
    idle(0, 12);

    // Zero-gap instance with continuous input.
    send(1, 16'h0101, 16'h0202);
    send(1, 16'h3E00, 16'h4200);
    repeat (20) send(1, 16'($urandom), 16'($urandom));
    idle(1, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
